// File: rtl/analyzer_mem_arbiter.sv
// Arbitrates the single memory command port between sampler writes and readback reads.
// Writes have priority up to a burst cap; reads are throttled by a consumer-credit counter.
module analyzer_mem_arbiter #(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int ADDR_WIDTH          = 27,
    parameter int MAX_WRITE_BURST     = 8,
    parameter int READ_CREDITS        = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           wr_req,
    input  logic [31:0]                    wr_sampleNumber,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] wr_data,
    output logic                           wr_grant,
    input  logic                           rd_req,
    input  logic [31:0]                    rd_sampleNumber,
    output logic                           read_allowed,
    input  logic                           rd_credit_return,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic                           mem_cmd_write,
    output logic [ADDR_WIDTH-1:0]          mem_cmd_addr,
    output logic [SAMPLE_PACKET_WIDTH-1:0] mem_cmd_wdata,
    output logic                           busy
);

    localparam int CREDIT_W = $clog2(READ_CREDITS + 1);
    localparam int BURST_W  = $clog2(MAX_WRITE_BURST + 1);
    localparam logic [CREDIT_W-1:0] CREDITS_FULL     = CREDIT_W'(READ_CREDITS);
    localparam logic [BURST_W-1:0]  BURST_CAP        = BURST_W'(MAX_WRITE_BURST);
    localparam logic [31:0]         BYTES_PER_PACKET = 32'(SAMPLE_PACKET_WIDTH / 8);

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_WRITE,
        SLOT_READ
    } slot_state_t;

    slot_state_t                    state_reg, state_next;
    logic [CREDIT_W-1:0]            credits_reg, credits_next;
    logic [BURST_W-1:0]             burst_cnt_reg, burst_cnt_next;
    logic [ADDR_WIDTH-1:0]          addr_reg, addr_next;
    logic [SAMPLE_PACKET_WIDTH-1:0] wdata_reg, wdata_next;

    logic                  slot_free;
    logic                  rd_eligible;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Byte address is formed in 32 bits and truncated; ring wrap belongs to the requester.
    assign wr_addr     = ADDR_WIDTH'(wr_sampleNumber * BYTES_PER_PACKET);
    assign rd_addr     = ADDR_WIDTH'(rd_sampleNumber * BYTES_PER_PACKET);
    assign slot_free   = (state_reg == SLOT_EMPTY) || mem_cmd_ready;
    assign rd_eligible = rd_req && (credits_reg != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= SLOT_EMPTY;
            credits_reg   <= CREDITS_FULL;
            burst_cnt_reg <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            credits_reg   <= credits_next;
            burst_cnt_reg <= burst_cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        credits_next   = credits_reg;
        burst_cnt_next = burst_cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wr_grant       = 1'b0;
        read_allowed   = 1'b0;

        if (slot_free) begin
            state_next = SLOT_EMPTY;
            if (wr_req && (!rd_eligible || (burst_cnt_reg < BURST_CAP))) begin
                wr_grant   = 1'b1;
                state_next = SLOT_WRITE;
                addr_next  = wr_addr;
                wdata_next = wr_data;
            end else if (rd_eligible) begin
                read_allowed = 1'b1;
                state_next   = SLOT_READ;
                addr_next    = rd_addr;
                wdata_next   = '0;
            end
        end

        // The cap only counts writes that overtook a waiting read.
        if (!rd_eligible) begin
            burst_cnt_next = '0;
        end else if (wr_grant && (burst_cnt_reg < BURST_CAP)) begin
            burst_cnt_next = burst_cnt_reg + BURST_W'(1);
        end else if (read_allowed) begin
            burst_cnt_next = '0;
        end

        if (read_allowed && !rd_credit_return) begin
            credits_next = credits_reg - CREDIT_W'(1);
        end else if (!read_allowed && rd_credit_return && (credits_reg != CREDITS_FULL)) begin
            credits_next = credits_reg + CREDIT_W'(1);
        end
    end

    assign mem_cmd_valid = (state_reg != SLOT_EMPTY);
    assign mem_cmd_write = (state_reg == SLOT_WRITE);
    assign mem_cmd_addr  = addr_reg;
    assign mem_cmd_wdata = wdata_reg;
    assign busy          = mem_cmd_valid || (credits_reg != CREDITS_FULL);

endmodule

// File: tb/tb_analyzer_mem_arbiter.sv
// Bench for analyzer_mem_arbiter: scenario tasks with inline checks plus a command scoreboard
// that predicts each memory command from the request payload at grant time.
module tb_analyzer_mem_arbiter;

    localparam int SPW = 32;
    localparam int AW  = 27;

    logic           clk;
    logic           reset_n;
    logic           wr_req;
    logic [31:0]    wr_sampleNumber;
    logic [SPW-1:0] wr_data;
    logic           wr_grant;
    logic           rd_req;
    logic [31:0]    rd_sampleNumber;
    logic           read_allowed;
    logic           rd_credit_return;
    logic           mem_cmd_valid;
    logic           mem_cmd_ready;
    logic           mem_cmd_write;
    logic [AW-1:0]  mem_cmd_addr;
    logic [SPW-1:0] mem_cmd_wdata;
    logic           busy;

    analyzer_mem_arbiter #(
        .SAMPLE_PACKET_WIDTH(SPW),
        .ADDR_WIDTH(AW),
        .MAX_WRITE_BURST(8),
        .READ_CREDITS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_req(wr_req),
        .wr_sampleNumber(wr_sampleNumber),
        .wr_data(wr_data),
        .wr_grant(wr_grant),
        .rd_req(rd_req),
        .rd_sampleNumber(rd_sampleNumber),
        .read_allowed(read_allowed),
        .rd_credit_return(rd_credit_return),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write),
        .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic           write;
        logic [AW-1:0]  addr;
        logic [SPW-1:0] wdata;
    } cmd_t;

    cmd_t sb_q[$];
    int   total;
    int   bad;

    function automatic logic [AW-1:0] byte_addr(input logic [31:0] sn);
        logic [31:0] full;
        full = sn * 32'd4;
        return full[AW-1:0];
    endfunction

    // Waits for the falling edge, retires any accepted command, then records new grants.
    task automatic sample();
        cmd_t got;
        cmd_t exp_cmd;
        @(negedge clk);
        if (reset_n && mem_cmd_valid && mem_cmd_ready) begin
            got = {mem_cmd_write, mem_cmd_addr, mem_cmd_wdata};
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_cmd got=%h required=none", got);
            end else begin
                exp_cmd = sb_q.pop_front();
                if (got !== exp_cmd) begin
                    bad++;
                    $display("FAIL sb_cmd got=%h required=%h", got, exp_cmd);
                end else begin
                    $display("txn write=%0b addr=%0d wdata=%h ok", got.write, got.addr, got.wdata);
                end
            end
        end
        if (wr_grant) begin
            exp_cmd = {1'b1, byte_addr(wr_sampleNumber), wr_data};
            sb_q.push_back(exp_cmd);
        end
        if (read_allowed) begin
            exp_cmd = {1'b0, byte_addr(rd_sampleNumber), {SPW{1'b0}}};
            sb_q.push_back(exp_cmd);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_credit_return = 1'b0;
        mem_cmd_ready = 1'b0; wr_sampleNumber = '0; rd_sampleNumber = '0; wr_data = '0;
        advance(); advance();
        sample();
        total++;
        if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, wr_grant, read_allowed, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b w=%b a=%0d d=%h g=%b r=%b busy=%b required all zero",
                     mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, wr_grant, read_allowed, busy);
        end
        advance();
        reset_n = 1'b1;
        advance();
    endtask

    task automatic test_single_write();
        wr_req = 1'b1; wr_sampleNumber = 32'd5; wr_data = 32'hDEAD_BEEF; mem_cmd_ready = 1'b1;
        sample();
        total++;
        if (wr_grant !== 1'b1) begin
            bad++;
            $display("FAIL single_wr_grant got=%b required=1", wr_grant);
        end
        advance();
        wr_req = 1'b0;
        sample();
        total++;
        if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy} !== {1'b1, 1'b1, 27'd20, 32'hDEAD_BEEF, 1'b1}) begin
            bad++;
            $display("FAIL single_wr_slot got v=%b w=%b a=%0d d=%h busy=%b required v=1 w=1 a=20 d=deadbeef busy=1",
                     mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata, busy);
        end
        advance();
        sample();
        total++;
        if (mem_cmd_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_wr_drain valid got=%b required=0", mem_cmd_valid);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic ret;
        logic bump;
        logic exp_w;
        ret = 1'b0;
        wr_req = 1'b1; rd_req = 1'b1; wr_sampleNumber = 32'd200; wr_data = 32'h1111_0000;
        rd_sampleNumber = 32'd100; mem_cmd_ready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            rd_credit_return = ret;
            sample();
            exp_w = ((i % 9) != 8);
            total++;
            if ({wr_grant, read_allowed} !== {exp_w, !exp_w}) begin
                bad++;
                $display("FAIL b2b_pattern cycle=%0d got g=%b r=%b required g=%b r=%b",
                         i, wr_grant, read_allowed, exp_w, !exp_w);
            end
            if ((i % 9) == 0 && i > 0) begin
                total++;
                if ({mem_cmd_write, mem_cmd_addr, mem_cmd_wdata} !== {1'b0, 27'd400, 32'h0}) begin
                    bad++;
                    $display("FAIL b2b_read_cmd got w=%b a=%0d d=%h required w=0 a=400 d=0",
                             mem_cmd_write, mem_cmd_addr, mem_cmd_wdata);
                end
            end
            ret  = read_allowed;
            bump = wr_grant;
            advance();
            if (bump) begin
                wr_sampleNumber = wr_sampleNumber + 32'd1;
                wr_data         = wr_data + 32'd1;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0; rd_credit_return = ret;
        sample();
        advance();
        rd_credit_return = 1'b0;
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy got=%b required=0", busy);
        end
        advance();
    endtask

    task automatic test_credits();
        int n;
        rd_req = 1'b0; rd_credit_return = 1'b1; mem_cmd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample(); advance();
        end
        rd_credit_return = 1'b0; rd_req = 1'b1; rd_sampleNumber = 32'd300;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (read_allowed) n++;
            advance();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL credit_stall reads got=%0d required=8", n);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL credit_busy got=%b required=1", busy);
        end
        rd_credit_return = 1'b1;
        sample();
        total++;
        if (read_allowed !== 1'b0) begin
            bad++;
            $display("FAIL credit_zero read_allowed got=%b required=0", read_allowed);
        end
        advance();
        rd_credit_return = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            if (read_allowed) n++;
            advance();
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL credit_one_return reads got=%0d required=1", n);
        end
    endtask

    task automatic test_coincident_credit();
        int n;
        rd_req = 1'b0; rd_credit_return = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample(); advance();
        end
        rd_req = 1'b1; rd_sampleNumber = 32'd400;
        sample();
        total++;
        if (read_allowed !== 1'b1) begin
            bad++;
            $display("FAIL coincident_grant got=%b required=1", read_allowed);
        end
        advance();
        rd_credit_return = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (read_allowed) n++;
            advance();
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL coincident_credits reads got=%0d required=3", n);
        end
        rd_req = 1'b0; rd_credit_return = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(); advance();
        end
        rd_credit_return = 1'b0;
        sample();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL credits_restored busy got=%b required=0", busy);
        end
        advance();
    endtask

    task automatic test_stall();
        wr_req = 1'b1; wr_sampleNumber = 32'd7; wr_data = 32'h0000_7777;
        rd_req = 1'b1; rd_sampleNumber = 32'd50; mem_cmd_ready = 1'b0;
        sample();
        total++;
        if (wr_grant !== 1'b1) begin
            bad++;
            $display("FAIL stall_first_grant got=%b required=1", wr_grant);
        end
        advance();
        wr_sampleNumber = 32'd8; wr_data = 32'h0000_8888;
        for (int i = 0; i < 5; i++) begin
            sample();
            total++;
            if ({wr_grant, read_allowed, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata}
                    !== {1'b0, 1'b0, 1'b1, 1'b1, 27'd28, 32'h0000_7777}) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got g=%b r=%b v=%b w=%b a=%0d d=%h required g=0 r=0 v=1 w=1 a=28 d=00007777",
                         i, wr_grant, read_allowed, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata);
            end
            advance();
        end
        mem_cmd_ready = 1'b1;
        sample();
        total++;
        if (wr_grant !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_grant got=%b required=1", wr_grant);
        end
        advance();
        wr_req = 1'b0; rd_req = 1'b0;
        sample(); advance();
        sample(); advance();
    endtask

    task automatic test_reset_mid();
        rd_req = 1'b1; rd_sampleNumber = 32'd60; mem_cmd_ready = 1'b1;
        sample(); advance();
        sample(); advance();
        rd_req = 1'b0; mem_cmd_ready = 1'b0;
        sample();
        total++;
        if (mem_cmd_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_setup valid got=%b required=1", mem_cmd_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({mem_cmd_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_async got v=%b busy=%b required v=0 busy=0", mem_cmd_valid, busy);
        end
        sb_q.delete();
        advance(); advance();
        reset_n = 1'b1; mem_cmd_ready = 1'b1;
        advance();
        sample();
        total++;
        if ({mem_cmd_valid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_release got v=%b busy=%b required v=0 busy=0", mem_cmd_valid, busy);
        end
        advance();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_credits();
        test_coincident_credit();
        test_stall();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
